// File: rtl/fetch_unit.sv
// RV32I instruction fetch stage with the IF/ID pipeline register.
// BOOT/RUN/HALT controller; taken branches redirect from the IF/ID PC plus ImmOp.
module fetch_unit #(
    parameter int ADDR_WIDTH  = 32,
    parameter int INSTR_WIDTH = 32,
    parameter int DATA_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic                   PCsrc,
    input  logic [DATA_WIDTH-1:0]  ImmOp,
    output logic                   imem_req,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0]  pc_out,
    output logic                   instr_valid,
    output logic                   fetch_err,
    output logic [31:0]            fetch_count
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t                 state, state_n;
    logic [ADDR_WIDTH-1:0]  fetch_pc, fetch_pc_n;
    logic [INSTR_WIDTH-1:0] instr_n;
    logic [ADDR_WIDTH-1:0]  pc_out_n;
    logic                   instr_valid_n;
    logic                   fetch_err_n;
    logic [31:0]            fetch_count_n;

    logic [ADDR_WIDTH-1:0]  imm_ext;
    logic [ADDR_WIDTH-1:0]  target;
    logic                   redirect;

    // A branch only counts when IF/ID holds a real instruction to branch from.
    assign imm_ext   = ADDR_WIDTH'($signed(ImmOp));
    assign target    = pc_out + imm_ext;
    assign redirect  = (state == RUN) && PCsrc && instr_valid;
    assign imem_req  = (state == RUN) && !stall && !redirect;
    assign imem_addr = fetch_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= BOOT;
            fetch_pc    <= RESET_PC;
            instr       <= '0;
            pc_out      <= '0;
            instr_valid <= 1'b0;
            fetch_err   <= 1'b0;
            fetch_count <= '0;
        end else begin
            state       <= state_n;
            fetch_pc    <= fetch_pc_n;
            instr       <= instr_n;
            pc_out      <= pc_out_n;
            instr_valid <= instr_valid_n;
            fetch_err   <= fetch_err_n;
            fetch_count <= fetch_count_n;
        end
    end

    always_comb begin
        state_n       = state;
        fetch_pc_n    = fetch_pc;
        instr_n       = instr;
        pc_out_n      = pc_out;
        instr_valid_n = instr_valid;
        fetch_err_n   = fetch_err;
        fetch_count_n = fetch_count;

        case (state)
            BOOT: begin
                state_n = RUN;
            end
            RUN: begin
                if (redirect) begin
                    instr_valid_n = 1'b0;
                    // A misaligned target is fatal; fetch_pc keeps its old value.
                    if (target[1:0] != 2'b00) begin
                        fetch_err_n = 1'b1;
                        state_n     = HALT;
                    end else begin
                        fetch_pc_n = target;
                    end
                end else if (!stall) begin
                    instr_n       = imem_rdata;
                    pc_out_n      = fetch_pc;
                    instr_valid_n = 1'b1;
                    fetch_pc_n    = fetch_pc + ADDR_WIDTH'(4);
                    fetch_count_n = fetch_count + 32'd1;
                end
            end
            HALT: begin
                instr_valid_n = 1'b0;
                fetch_err_n   = 1'b1;
            end
            default: begin
                state_n = BOOT;
            end
        endcase
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage and IF/ID pipeline register for the RV32I core. It holds the program counter and drives the instruction-memory address. It latches the returned word into the IF/ID register for decode, where the immediate is extracted. On a taken branch it redirects using the sign-extended immediate (ImmOp) returned from decode.

## Interface
Parameters:
- ADDR_WIDTH, 32, PC and instruction-memory address width
- INSTR_WIDTH, 32, instruction word width
- DATA_WIDTH, 32, width of ImmOp
- RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold fetch_pc and IF/ID contents
- PCsrc  in  1  branch taken for the instruction currently in IF/ID
- ImmOp  in  DATA_WIDTH  sign-extended branch offset for the IF/ID instruction
- imem_req  out  1  fetch request; combinational, high in RUN when not stalled and not redirecting
- imem_addr  out  ADDR_WIDTH  equals fetch_pc; combinational
- imem_rdata  in  INSTR_WIDTH  instruction at imem_addr; combinational (same-cycle) read
- instr  out  INSTR_WIDTH  IF/ID instruction
- pc_out  out  ADDR_WIDTH  PC of instr
- instr_valid  out  1  IF/ID holds a real instruction
- fetch_err  out  1  sticky misaligned-redirect error
- fetch_count  out  32  number of instructions loaded into IF/ID; wraps

## Operation
- States:
  - BOOT: first cycle after reset.
  - RUN: normal fetch.
  - HALT: error; left only by rst.
- Priority each cycle: rst > HALT > redirect > stall > normal fetch.
- BOOT:
  - imem_req=0 and IF/ID is not loaded.
  - Next state is RUN unconditionally; stall and PCsrc are ignored.
- RUN, redirect (PCsrc=1 and instr_valid=1):
  - target = pc_out + ImmOp, modulo 2^ADDR_WIDTH.
  - If target[1:0] != 0: fetch_err<=1, instr_valid<=0, state<=HALT; fetch_pc is unchanged.
  - Otherwise: fetch_pc<=target, instr_valid<=0 (one-cycle bubble), instr and pc_out unchanged.
  - imem_req=0 in a redirect cycle, and the fetched word is discarded.
  - A redirect takes effect even if stall=1.
- RUN, PCsrc=1 with instr_valid=0: PCsrc is ignored.
- RUN, stall=1 (no redirect): all registers hold; imem_req=0.
- RUN, normal fetch:
  - instr<=imem_rdata, pc_out<=fetch_pc, instr_valid<=1.
  - fetch_pc<=fetch_pc+4 (wraps from 32'hFFFF_FFFC to 0).
  - fetch_count<=fetch_count+1.
- HALT: imem_req=0 and instr_valid=0; fetch_pc, instr, pc_out and fetch_count are frozen; fetch_err=1.
- fetch_count increments only on an IF/ID load of a real instruction. It is not incremented on bubbles, stalls or redirects, and it wraps at 2^32.

## Timing
- Reset values, one edge with rst=1:
  - fetch_pc=RESET_PC, state=BOOT
  - instr=0, pc_out=0, instr_valid=0
  - fetch_err=0, fetch_count=0
- rst asserted mid-operation, including in HALT or during a stall, returns everything to these values on the next edge.
- Latency after rst falls:
  - Cycle 0 is BOOT.
  - Cycle 1 presents RESET_PC with imem_req=1.
  - At the end of cycle 1, instr_valid=1 with pc_out=RESET_PC.
- Throughput: one instruction per cycle in RUN without stall.
- Taken-branch penalty is exactly one bubble cycle. The target instruction appears in IF/ID two edges after the edge at which PCsrc is sampled high.
- All outputs except imem_req and imem_addr are registered.

## Test plan
- Reset/boot, RESET_PC=0, imem word = 32'h00A00093 at address 0: rst 2 cycles, release -> BOOT cycle with imem_req=0; next edge instr=32'h00A00093, pc_out=0, instr_valid=1, fetch_count=1; sequential pc_out 0,4,8,C on the following edges.
- Stall: stall=1 for 3 cycles at pc_out=8 -> instr, pc_out, fetch_pc and fetch_count held; imem_req=0; fetch resumes at 12 with no skip and no duplicate.
- Taken branch at pc_out=16 with ImmOp=32'hFFFF_FFF8 -> one edge with instr_valid=0 and imem_req=0; next edge pc_out=8, instr_valid=1; fetch_count rises by 1, not 2.
- Branch during stall, and PCsrc on a bubble: PCsrc=1 with stall=1 at pc_out=0, ImmOp=32'h40 -> redirect happens and pc_out=32'h40 two edges later. PCsrc=1 while instr_valid=0 -> ignored, PC continues +4.
- Misaligned target: pc_out=4, ImmOp=32'h6 -> fetch_err=1, instr_valid=0, HALT persists for 10 cycles with fetch_count frozen; rst pulse clears fetch_err and reboots at RESET_PC.
- Wrap: RESET_PC=32'hFFFF_FFF8 -> pc_out sequence FFFF_FFF8, FFFF_FFFC, 0000_0000; branch target pc_out + ImmOp also wraps (FFFF_FFFC + 8 -> 4).
